// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O block: register offsets,
// STATUS bit positions and the active-low hex-to-segment table.
package io_pkg;

   localparam logic [3:0] IO_LED    = 4'h0;
   localparam logic [3:0] IO_SW     = 4'h4;
   localparam logic [3:0] IO_TIMER  = 4'h8;
   localparam logic [3:0] IO_STATUS = 4'hC;

   localparam int ST_EXPIRED    = 0;
   localparam int ST_ENABLE     = 1;
   localparam int ST_AUTORELOAD = 2;

   // Segments g..a, active-low; entry n is the glyph for hex digit n.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/io_controller_sevenseg_scan.sv
// Multiplexed 4-digit seven-segment scanner showing a 16-bit value in hex.
// Instantiated by io_controller only when IO_SEVENSEG_EN is defined.
module sevenseg_scan
   import io_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] leds,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [SW-1:0] r_scan;
   logic [1:0]    r_digit;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic [15:0]   w_shift;
   logic [3:0]    w_nibble;

   assign w_shift  = leds >> {r_digit, 2'b00};
   assign w_nibble = w_shift[3:0];

   // Outputs are registered so reset blanks the display asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan  <= '0;
         r_digit <= 2'd0;
         r_an    <= 4'hF;
         r_seg   <= 7'h7F;
      end else begin
         if (r_scan == SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
         end else begin
            r_scan <= r_scan + 1'b1;
         end
         r_an  <= ~(4'b0001 << r_digit);
         r_seg <= SEG_HEX[w_nibble];
      end
   end

   assign an  = r_an;
   assign seg = r_seg;

endmodule

// File: rtl/io_controller.sv
// I/O window peripheral: LED/switch registers, prescaled down-counting timer
// and status, with combinational read-back. IO_SEVENSEG_EN adds the display scanner.
module io_controller
   import io_pkg::*;
#(
   parameter int PRESCALE = 50,
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  io_addr,
   input  logic        io_write_en,
   input  logic [31:0] io_write_data,
   output logic [31:0] io_read_data,
   input  logic [15:0] switches,
   output logic [15:0] leds,
   output logic        irq,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [15:0]   r_leds;
   logic [15:0]   r_sw_meta;
   logic [15:0]   r_sw_sync;
   logic [31:0]   r_count;
   logic [31:0]   r_reload;
   logic          r_enable;
   logic          r_autoreload;
   logic          r_expired;
   logic [PW-1:0] r_pre;

   logic [1:0] w_sel;
   logic       w_wr_led;
   logic       w_wr_timer;
   logic       w_wr_status;
   logic       w_tick;
   logic       w_expire;
   logic       w_clear;
   logic       w_unused;

   assign w_sel       = io_addr[3:2];
   assign w_wr_led    = io_write_en && (w_sel == IO_LED[3:2]);
   assign w_wr_timer  = io_write_en && (w_sel == IO_TIMER[3:2]);
   assign w_wr_status = io_write_en && (w_sel == IO_STATUS[3:2]);
   assign w_clear     = w_wr_status && io_write_data[ST_EXPIRED];

   // A TIMER load or an enable-clearing STATUS write swallows the tick.
   assign w_tick   = r_enable && (r_pre == PRE_LAST) && !w_wr_timer &&
                     !(w_wr_status && !io_write_data[ST_ENABLE]);
   assign w_expire = w_tick && (r_count == 32'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
         r_leds    <= '0;
      end else begin
         r_sw_meta <= switches;
         r_sw_sync <= r_sw_meta;
         if (w_wr_led) r_leds <= io_write_data[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre <= '0;
      end else if (!r_enable || w_wr_timer || (r_pre == PRE_LAST)) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count  <= '0;
         r_reload <= '0;
      end else if (w_wr_timer) begin
         r_count  <= io_write_data;
         r_reload <= io_write_data;
      end else if (w_tick) begin
         if (r_count > 32'd1)
            r_count <= r_count - 32'd1;
         else if (r_count == 32'd1)
            r_count <= r_autoreload ? r_reload : 32'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_enable     <= 1'b0;
         r_autoreload <= 1'b0;
         r_expired    <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_enable     <= io_write_data[ST_ENABLE];
            r_autoreload <= io_write_data[ST_AUTORELOAD];
         end
         r_expired <= w_expire || (r_expired && !w_clear);
      end
   end

   always_comb begin
      io_read_data = '0;
      case (w_sel)
         IO_LED[3:2]:   io_read_data = {16'h0, r_leds};
         IO_SW[3:2]:    io_read_data = {16'h0, r_sw_sync};
         IO_TIMER[3:2]: io_read_data = r_count;
         default: begin
            io_read_data[ST_EXPIRED]    = r_expired;
            io_read_data[ST_ENABLE]     = r_enable;
            io_read_data[ST_AUTORELOAD] = r_autoreload;
         end
      endcase
   end

   assign leds = r_leds;
   assign irq  = r_expired;

`ifdef IO_SEVENSEG_EN
   assign w_unused = &{1'b0, io_addr[1:0]};

   sevenseg_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk   (clk),
      .reset (reset),
      .leds  (r_leds),
      .an    (an),
      .seg   (seg)
   );
`else
   assign w_unused = &{1'b0, io_addr[1:0], SCAN_DIV > 0};
   assign an       = 4'hF;
   assign seg      = 7'h7F;
`endif

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed scenarios plus random bus
// traffic compared every cycle against a register-level reference model.
module tb_io_controller;

   localparam int P  = 4;
   localparam int SD = 2;

   logic        clk;
   logic        reset;
   logic [3:0]  io_addr;
   logic        io_write_en;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic [15:0] switches;
   logic [15:0] leds;
   logic        irq;
   logic [3:0]  an;
   logic [6:0]  seg;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_leds, m_sw1, m_sw2;
   logic [31:0] m_count, m_reload;
   bit          m_en, m_auto, m_exp;
   int          m_phase;

   io_controller #(.PRESCALE(P), .SCAN_DIV(SD)) dut (
      .clk           (clk),
      .reset         (reset),
      .io_addr       (io_addr),
      .io_write_en   (io_write_en),
      .io_write_data (io_write_data),
      .io_read_data  (io_read_data),
      .switches      (switches),
      .leds          (leds),
      .irq           (irq),
      .an            (an),
      .seg           (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
         4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
         4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
         4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
         4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
         4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
         4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
         4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    m_read = {16'h0, m_leds};
         2'd1:    m_read = {16'h0, m_sw2};
         2'd2:    m_read = m_count;
         default: m_read = {29'h0, m_auto, m_en, m_exp};
      endcase
   endfunction

   // True when the coming edge would decrement the timer given this bus cycle.
   function automatic bit m_tick(input logic we, input logic [3:0] a, input logic [31:0] d);
      m_tick = m_en && (m_phase == P - 1) && !(we && a[3:2] == 2'd2) &&
               !(we && a[3:2] == 2'd3 && !d[1]);
   endfunction

   task automatic m_reset();
      m_leds = '0; m_sw1 = '0; m_sw2 = '0;
      m_count = '0; m_reload = '0;
      m_en = 0; m_auto = 0; m_exp = 0; m_phase = 0;
   endtask

   // One bus cycle: drive, check read, advance model across the edge, check outputs.
   task automatic cyc(input logic we, input logic [3:0] a, input logic [31:0] d);
      logic [31:0] n_count, n_reload;
      logic [15:0] n_leds, n_sw1, n_sw2;
      bit          n_en, n_auto, n_exp, tk, set;
      int          n_phase;
      io_write_en = we; io_addr = a; io_write_data = d;
      #1;
      chk("read", io_read_data, m_read(a));
      tk = m_tick(we, a, d);
      set = 0;
      n_count = m_count; n_reload = m_reload;
      if (we && a[3:2] == 2'd2) begin
         n_count = d; n_reload = d;
      end else if (tk) begin
         if (m_count > 1) n_count = m_count - 1;
         else if (m_count == 1) begin
            n_count = m_auto ? m_reload : 32'd0;
            set = 1;
         end
      end
      n_phase = (!m_en || (we && a[3:2] == 2'd2)) ? 0 : (m_phase + 1) % P;
      n_exp   = set || (m_exp && !(we && a[3:2] == 2'd3 && d[0]));
      n_en    = (we && a[3:2] == 2'd3) ? d[1] : m_en;
      n_auto  = (we && a[3:2] == 2'd3) ? d[2] : m_auto;
      n_leds  = (we && a[3:2] == 2'd0) ? d[15:0] : m_leds;
      n_sw1   = switches;
      n_sw2   = m_sw1;
      @(posedge clk);
      m_count = n_count; m_reload = n_reload; m_phase = n_phase;
      m_exp = n_exp; m_en = n_en; m_auto = n_auto; m_leds = n_leds;
      m_sw1 = n_sw1; m_sw2 = n_sw2;
      @(negedge clk);
      chk("irq", {31'h0, irq}, {31'h0, m_exp});
      chk("leds", {16'h0, leds}, {16'h0, m_leds});
   endtask

   initial begin
      int n;
      int rises[$];
      bit prev_irq;
      logic        rw;
      logic [3:0]  ra;
      logic [31:0] rd;

      reset = 1'b1; io_write_en = 1'b0; io_addr = 4'h0; io_write_data = '0;
      switches = '0;
      m_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_leds", {16'h0, leds}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_an", {28'h0, an}, 32'hF);
      chk("rst_seg", {25'h0, seg}, 32'h7F);
      for (int i = 0; i < 4; i++) begin
         io_addr = 4'(i * 4);
         #1;
         chk("rst_read", io_read_data, 32'h0);
      end
      reset = 1'b0;

      // LED register and read-only switch register
      cyc(1, 4'h0, 32'h0000ABCD);
      chk("led_pins", {16'h0, leds}, 32'h0000ABCD);
      cyc(0, 4'h0, 32'h0);
      cyc(1, 4'h4, 32'hFFFFFFFF);
      cyc(0, 4'h6, 32'h0);

      // Switch synchroniser latency
      switches = 16'h00F0;
      cyc(0, 4'h4, 32'h0);
      cyc(0, 4'h4, 32'h0);
      io_addr = 4'h4; io_write_en = 0;
      #1;
      chk("sw_lat2", io_read_data, 32'h000000F0);

      // One-shot timer: expiry PRESCALE*N cycles after the enabling edge
      cyc(1, 4'h8, 32'd3);
      cyc(1, 4'hC, 32'h2);
      n = 0;
      for (int g = 0; g < 40 && !irq; g++) begin
         cyc(0, 4'h8, 32'h0);
         n++;
      end
      chk("irq_latency", 32'(n), 32'd12);
      for (int g = 0; g < 6; g++) cyc(0, 4'h8, 32'h0);
      chk("count_stays0", m_read(4'h8) ^ io_read_data, 32'h0);
      cyc(1, 4'hC, 32'h1);
      chk("irq_cleared", {31'h0, irq}, 32'h0);

      // Autoreload: expiry every 8 cycles with count 2,1,2,1...
      cyc(1, 4'h8, 32'd2);
      cyc(1, 4'hC, 32'h6);
      prev_irq = 0;
      for (int g = 0; g < 40; g++) begin
         if (irq && !prev_irq) rises.push_back(g);
         prev_irq = irq;
         if (irq) cyc(1, 4'hC, 32'h7);
         else     cyc(0, 4'h8, 32'h0);
      end
      chk("auto_rises", 32'(rises.size() >= 3), 32'd1);
      for (int i = 1; i < rises.size(); i++)
         chk("auto_period", 32'(rises[i] - rises[i-1]), 32'd8);

      // Collisions: TIMER write in the tick cycle, clear write in the expiry cycle
      cyc(1, 4'hC, 32'h1);
      cyc(1, 4'h8, 32'd20);
      cyc(1, 4'hC, 32'h2);
      for (int g = 0; g < 20 && !m_tick(0, 4'h0, 32'h0); g++) cyc(0, 4'h8, 32'h0);
      chk("tick_found", {31'h0, m_tick(0, 4'h0, 32'h0)}, 32'h1);
      cyc(1, 4'h8, 32'd5);
      io_write_en = 0; io_addr = 4'h8;
      #1;
      chk("tw_wins", io_read_data, 32'd5);
      for (int g = 0; g < 40 && !(m_count == 1 && m_tick(0, 4'h0, 32'h0)); g++)
         cyc(0, 4'h8, 32'h0);
      chk("exp_found", {31'h0, m_tick(0, 4'h0, 32'h0)}, 32'h1);
      cyc(1, 4'hC, 32'h3);
      chk("set_wins", {31'h0, irq}, 32'h1);

      // Random bus traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) switches = 16'($urandom);
         rw = ($urandom_range(0, 2) == 0);
         ra = 4'($urandom_range(0, 15));
         if (ra[3:2] == 2'd2)      rd = 32'($urandom_range(0, 6));
         else if (ra[3:2] == 2'd3) rd = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'h2 : 32'h0);
         else                      rd = $urandom;
         cyc(rw, ra, rd);
      end

      // Reset mid-count aborts with no expiry
      cyc(1, 4'h0, 32'h5A5A);
      cyc(1, 4'hC, 32'h1);
      cyc(1, 4'h8, 32'd3);
      cyc(1, 4'hC, 32'h2);
      for (int g = 0; g < 5; g++) cyc(0, 4'h8, 32'h0);
      #2;
      reset = 1'b1; io_write_en = 0; io_addr = 4'h8;
      #1;
      chk("arst_count", io_read_data, 32'h0);
      chk("arst_leds", {16'h0, leds}, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      chk("arst_an", {28'h0, an}, 32'hF);
      chk("arst_seg", {25'h0, seg}, 32'h7F);
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int g = 0; g < 20; g++) cyc(0, 4'h8, 32'h0);

`ifdef IO_SEVENSEG_EN
      begin
         int k, pk;
         cyc(1, 4'h0, 32'h1234);
         cyc(0, 4'h0, 32'h0);
         cyc(0, 4'h0, 32'h0);
         pk = -1;
         for (int g = 0; g < 20; g++) begin
            case (an)
               4'hE: k = 0;
               4'hD: k = 1;
               4'hB: k = 2;
               4'h7: k = 3;
               default: k = -1;
            endcase
            chk("an_onehot", 32'(k >= 0), 32'd1);
            if (k >= 0) begin
               chk("seg_digit", {25'h0, seg}, {25'h0, seg_of(4'(m_leds >> (4 * k)))});
               if (pk >= 0 && k != pk) chk("an_order", 32'(k), 32'((pk + 1) % 4));
               pk = k;
            end
            cyc(0, 4'h0, 32'h0);
         end
         #2;
         reset = 1'b1;
         #1;
         chk("scan_rst_an", {28'h0, an}, 32'hF);
         chk("scan_rst_seg", {25'h0, seg}, 32'h7F);
         m_reset();
         @(negedge clk);
         reset = 1'b0;
      end
`else
      cyc(1, 4'h0, 32'h1234);
      for (int g = 0; g < 5; g++) begin
         cyc(0, 4'h0, 32'h0);
         chk("an_off", {28'h0, an}, 32'hF);
         chk("seg_off", {25'h0, seg}, 32'h7F);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
